// File: rtl/flush_controller_if.sv
// Redirect/flush handshake bundle between the pipeline and the flush
// controller. The pipeline drives the master side; the controller is the
// slave.
interface flush_controller_if #(
  parameter int NUM_SRC    = 3,
  parameter int NUM_STAGES = 2,
  parameter int ADDR_W     = 32
);
  logic [NUM_SRC-1:0]        redirect_valid;
  logic [NUM_SRC*ADDR_W-1:0] redirect_target;
  logic                      stall;
  logic [NUM_STAGES-1:0]     flush;
  logic                      pc_redirect_valid;
  logic [ADDR_W-1:0]         pc_redirect_target;
  logic                      busy;

  modport master (
    output redirect_valid, redirect_target, stall,
    input  flush, pc_redirect_valid, pc_redirect_target, busy
  );

  modport slave (
    input  redirect_valid, redirect_target, stall,
    output flush, pc_redirect_valid, pc_redirect_target, busy
  );
endinterface

// File: rtl/flush_controller.sv
// flush_controller: picks the highest-priority redirect source (index 0 =
// oldest stage), steers the PC and flushes the front-end registers. Younger
// redirects seen while the flushed instructions drain (SHADOW) are wrong-path
// and dropped; a redirect that arrives while the PC is stalled is parked
// (PENDING) until the stall releases.
// Optional: define FLUSH_CONTROLLER_STATS_EN to add a saturating 16-bit
// flush_count output that counts issued redirects.
module flush_controller #(
  parameter int NUM_SRC    = 3,
  parameter int NUM_STAGES = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  flush_controller_if.slave bus
`ifdef FLUSH_CONTROLLER_STATS_EN
  ,
  output logic [15:0]       flush_count
`endif
);

  localparam int CNT_W = $clog2(NUM_STAGES) + 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SHADOW, PENDING} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] target_reg, target_next;

  logic [ADDR_W-1:0]     src_target [NUM_SRC];
  logic                  sel_valid;
  logic [ADDR_W-1:0]     sel_target;
  logic                  accept;
  logic [ADDR_W-1:0]     accept_target;
  logic                  issue;
  logic [ADDR_W-1:0]     issue_target;
  logic [NUM_STAGES-1:0] flush_c;

  // Unpack the flat target bus into one entry per source.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_target[gi] = bus.redirect_target[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Fixed priority: scan from youngest to oldest so the lowest set index wins.
  always_comb begin
    sel_valid  = 1'b0;
    sel_target = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.redirect_valid[i]) begin
        sel_valid  = 1'b1;
        sel_target = src_target[i];
      end
    end
  end

  // Next-state, shadow counter, parked target and combinational outputs.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    target_next   = target_reg;
    accept        = 1'b0;
    accept_target = '0;
    issue         = 1'b0;
    issue_target  = '0;
    flush_c       = '0;

    case (state_reg)
      IDLE: begin
        if (sel_valid) begin
          accept        = 1'b1;
          accept_target = sel_target;
        end
      end
      SHADOW: begin
        // Only the oldest source can be on the correct path here.
        if (bus.redirect_valid[0]) begin
          accept        = 1'b1;
          accept_target = src_target[0];
        end else if (cnt_reg <= CNT_ONE) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      PENDING: begin
        // New requests are ignored; keep squashing until the PC can load.
        flush_c = '1;
        if (!bus.stall) begin
          issue        = 1'b1;
          issue_target = target_reg;
        end
      end
      default: state_next = IDLE;
    endcase

    if (accept) begin
      flush_c = '1;
      if (bus.stall) begin
        target_next = accept_target;
        cnt_next    = '0;
        state_next  = PENDING;
      end else begin
        issue        = 1'b1;
        issue_target = accept_target;
      end
    end

    // A single-register front end has nothing left to drain after the flush.
    if (issue) begin
      if (NUM_STAGES == 1) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        state_next = SHADOW;
        cnt_next   = CNT_RELOAD;
      end
    end
  end

  // Outputs are forced low while reset is held, whatever the inputs are doing.
  assign bus.flush              = rst ? '0 : flush_c;
  assign bus.pc_redirect_valid  = rst ? 1'b0 : issue;
  assign bus.pc_redirect_target = rst ? '0 : issue_target;
  assign bus.busy               = rst ? 1'b0 : (state_reg != IDLE);

  // State register; reset discards any parked redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      target_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      target_reg <= target_next;
    end
  end

`ifdef FLUSH_CONTROLLER_STATS_EN
  // Saturating count of redirects actually delivered to the PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_count <= '0;
    end else if (issue && (flush_count != 16'hFFFF)) begin
      flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule
